// File: rtl/tinyml_cam_raw_line_buffer_if.sv
// Pixel-stream bundle for the RAW line buffer.
// Carries the incoming 2PPC pair and the three-row window outputs.
interface tinyml_cam_raw_line_buffer_if #(
  parameter int PW = 20
);
  logic          i_vsync;
  logic          i_valid;
  logic [PW-1:0] i_data;
  logic          o_vsync;
  logic          o_valid;
  logic [PW-1:0] o_p_11;
  logic [PW-1:0] o_p_00;
  logic [PW-1:0] o_p_01;

  modport master (
    output i_vsync,
    output i_valid,
    output i_data,
    input  o_vsync,
    input  o_valid,
    input  o_p_11,
    input  o_p_00,
    input  o_p_01
  );

  modport slave (
    input  i_vsync,
    input  i_valid,
    input  i_data,
    output o_vsync,
    output o_valid,
    output o_p_11,
    output o_p_00,
    output o_p_01
  );
endinterface

// File: rtl/tinyml_cam_raw_line_buffer.sv
// Three-row line buffer for 2PPC Bayer RAW ahead of the debayer.
// Two cascaded line RAMs give top/centre rows; bottom row is live data.
module tinyml_cam_raw_line_buffer #(
  parameter int P_DEPTH      = 10,
  parameter int PW           = P_DEPTH * 2,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input logic                         i_pclk,
  input logic                         i_arstn,
  tinyml_cam_raw_line_buffer_if.slave bus
);

  localparam int WORDS = FRAME_WIDTH / 2;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

  logic [PW-1:0] lb0 [WORDS];
  logic [PW-1:0] lb1 [WORDS];

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic          frame_start;

  logic          vsync_s1;
  logic          valid_s1;
  logic [PW-1:0] data_s1;
  logic [CW-1:0] col_s1;
  logic [RW-1:0] row_s1;

  logic [PW-1:0] rd0;
  logic [PW-1:0] rd1;

  // Frame-start override and column/row advance for the accepted pair.
  always_comb begin
    frame_start = vsync_s1 & ~bus.i_vsync;
    col_cur     = frame_start ? '0 : col;
    row_cur     = frame_start ? '0 : row;
    col_nxt     = col_cur;
    row_nxt     = row_cur;
    if (bus.i_valid) begin
      if (col_cur == COL_LAST) begin
        col_nxt = '0;
        if (row_cur != ROW_LAST) begin
          row_nxt = row_cur + RW'(1);
        end
      end else begin
        col_nxt = col_cur + CW'(1);
      end
    end
  end

  // Position counters; row saturates on the last line.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Stage S1: capture the pair and where it sits in the frame.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      vsync_s1 <= 1'b0;
      valid_s1 <= 1'b0;
      data_s1  <= '0;
      col_s1   <= '0;
      row_s1   <= '0;
    end else begin
      vsync_s1 <= bus.i_vsync;
      valid_s1 <= bus.i_valid;
      if (bus.i_valid) begin
        data_s1 <= bus.i_data;
        col_s1  <= col_cur;
        row_s1  <= row_cur;
      end
    end
  end

  // Line RAMs: read in S1, cascade write one cycle later (read-first).
  always_ff @(posedge i_pclk) begin
    if (bus.i_valid) begin
      rd0 <= lb0[col_cur];
      rd1 <= lb1[col_cur];
    end
    if (valid_s1) begin
      lb0[col_s1] <= data_s1;
      lb1[col_s1] <= rd0;
    end
  end

  // Output window; rows older than the frame start are masked to zero.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      bus.o_vsync <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_p_01  <= '0;
      bus.o_p_00  <= '0;
      bus.o_p_11  <= '0;
    end else begin
      bus.o_vsync <= vsync_s1;
      bus.o_valid <= valid_s1;
      if (valid_s1) begin
        bus.o_p_01 <= data_s1;
        bus.o_p_00 <= (row_s1 == '0) ? '0 : rd0;
        bus.o_p_11 <= (row_s1 < RW'(2)) ? '0 : rd1;
      end
    end
  end

endmodule
